// File: rtl/vga_text_pkg.sv
// Shared constants and types for the text-mode screen path.
// The 80x30 character grid is addressed row-major.
package vga_text_pkg;

    localparam int TEXT_COLS     = 80;
    localparam int TEXT_ROWS     = 30;
    localparam int SCREEN_ADDR_W = 12;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } fw_state_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational map from a 4-bit nibble to its uppercase hexadecimal ASCII code.
module nibble_to_ascii
    import vga_text_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    // Digits 0-9 and letters A-F sit in two separate runs of the ASCII table.
    always_comb begin
        ascii_o = ASCII_ZERO;
        if (nibble_i < 4'd10) begin
            ascii_o = ASCII_ZERO + {4'h0, nibble_i};
        end else begin
            ascii_o = ASCII_A + {4'h0, nibble_i} - 8'd10;
        end
    end

endmodule

// File: rtl/hex_field_writer.sv
// Writes a DIGITS-wide hexadecimal field into screen RAM, one character per clock,
// with optional leading-zero blanking, right-edge clipping and auto-refresh.
module hex_field_writer
    import vga_text_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int COLS   = TEXT_COLS,
    parameter int ROWS   = TEXT_ROWS,
    parameter int ADDR_W = SCREEN_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [4:0]            row,
    input  logic [6:0]            col,
    input  logic                  blank_lz,
    input  logic                  auto_en,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  ram_we,
    output logic [7:0]            ram_data
);

    localparam int         VAL_W    = 4 * DIGITS;
    localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);

    fw_state_t           state_q, state_d;
    logic [VAL_W-1:0]    val_q, val_d;
    logic [VAL_W-1:0]    last_q, last_d;
    logic                valid_q, valid_d;
    logic [4:0]          row_q, row_d;
    logic [6:0]          col_q, col_d;
    logic                blz_q, blz_d;
    logic [3:0]          idx_q, idx_d;
    logic                nz_seen_q, nz_seen_d;

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          data_q, data_d;

    logic                trigger_s;
    logic [3:0]          rev_idx_s;
    logic [VAL_W-1:0]    shift_s;
    logic [3:0]          nib_s;
    logic [7:0]          hex_char_s;
    logic [7:0]          char_s;
    logic                lead_zero_s;
    logic [7:0]          col_sum_s;
    logic [ADDR_W-1:0]   row_base_s;
    logic [ADDR_W-1:0]   addr_s;
    logic                in_range_s;

    assign trigger_s = start | (auto_en & ((value != last_q) | ~valid_q));

    // Digit index 0 is the most significant nibble of the captured value.
    assign rev_idx_s = LAST_IDX - idx_q;
    assign shift_s   = val_q >> {rev_idx_s, 2'b00};
    assign nib_s     = shift_s[3:0];

    nibble_to_ascii u_nibble_to_ascii (
        .nibble_i (nib_s),
        .ascii_o  (hex_char_s)
    );

    // The least significant digit is never blanked so a zero value still shows "0".
    assign lead_zero_s = blz_q & ~nz_seen_q & (nib_s == 4'h0) & (idx_q != LAST_IDX);
    assign char_s      = lead_zero_s ? ASCII_SPACE : hex_char_s;

    assign col_sum_s  = {1'b0, col_q} + {4'h0, idx_q};
    assign row_base_s = ADDR_W'(row_q) * ADDR_W'(COLS);
    assign addr_s     = row_base_s + ADDR_W'(col_sum_s);
    assign in_range_s = (int'(row_q) < ROWS) && (int'(col_sum_s) < COLS);

    // Next-state and next-output logic for the IDLE -> WRITE -> DONE sequence.
    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        last_d    = last_q;
        valid_d   = valid_q;
        row_d     = row_q;
        col_d     = col_q;
        blz_d     = blz_q;
        idx_d     = idx_q;
        nz_seen_d = nz_seen_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;

        case (state_q)
            IDLE: begin
                if (trigger_s) begin
                    val_d     = value;
                    row_d     = row;
                    col_d     = col;
                    blz_d     = blank_lz;
                    idx_d     = 4'd0;
                    nz_seen_d = 1'b0;
                    state_d   = WRITE;
                end else begin
                    state_d   = IDLE;
                end
            end
            WRITE: begin
                busy_d    = 1'b1;
                we_d      = in_range_s;
                addr_d    = addr_s;
                data_d    = char_s;
                nz_seen_d = nz_seen_q | (nib_s != 4'h0);
                if (idx_q == LAST_IDX) begin
                    last_d  = val_q;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = WRITE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any field in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            val_q     <= {VAL_W{1'b0}};
            last_q    <= {VAL_W{1'b0}};
            valid_q   <= 1'b0;
            row_q     <= 5'd0;
            col_q     <= 7'd0;
            blz_q     <= 1'b0;
            idx_q     <= 4'd0;
            nz_seen_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            row_q     <= row_d;
            col_q     <= col_d;
            blz_q     <= blz_d;
            idx_q     <= idx_d;
            nz_seen_q <= nz_seen_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ram_we   = we_q;
    assign ram_addr = addr_q;
    assign ram_data = data_q;

endmodule

// File: tb/tb_hex_field_writer.sv
// Randomised self-checking bench for hex_field_writer against a character-level
// reference model (digit extraction by shifting, clipping and blanking by arithmetic).
module tb_hex_field_writer;

    localparam int DIGITS = 4;
    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 12;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [15:0]        value;
    logic [4:0]         row;
    logic [6:0]         col;
    logic               blank_lz;
    logic               auto_en;
    logic               busy;
    logic               done;
    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_we;
    logic [7:0]         ram_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic               obs_busy [0:5];
    logic               obs_we   [0:5];
    logic               obs_done [0:5];
    logic [ADDR_W-1:0]  obs_addr [0:5];
    logic [7:0]         obs_data [0:5];

    always #5 clk = ~clk;

    hex_field_writer #(
        .DIGITS (DIGITS),
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .value    (value),
        .row      (row),
        .col      (col),
        .blank_lz (blank_lz),
        .auto_en  (auto_en),
        .busy     (busy),
        .done     (done),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_data (ram_data)
    );

    // Character shown at screen position i (0 = leftmost) for value v.
    function automatic logic [7:0] model_char(input logic [15:0] v, input int i, input logic blz);
        int vi;
        int upper;
        int d;
        vi    = int'(v);
        upper = vi >> (4 * (DIGITS - 1 - i));
        d     = upper & 15;
        if (blz && (i < DIGITS - 1) && (upper == 0)) return 8'h20;
        if (d < 10) return 8'(48 + d);
        return 8'(55 + d);
    endfunction

    function automatic logic model_we(input int r, input int c, input int i);
        return (r < ROWS) && (c + i < COLS);
    endfunction

    function automatic logic [ADDR_W-1:0] model_addr(input int r, input int c, input int i);
        return ADDR_W'((r * COLS + c + i) % (1 << ADDR_W));
    endfunction

    // Pulses start for one cycle and records the six cycles following the trigger edge.
    task automatic pulse_and_capture(input logic [15:0] v, input logic [4:0] r,
                                     input logic [6:0] c, input logic blz);
        value    = v;
        row      = r;
        col      = c;
        blank_lz = blz;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            obs_busy[k] = busy;
            obs_we[k]   = ram_we;
            obs_done[k] = done;
            obs_addr[k] = ram_addr;
            obs_data[k] = ram_data;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; value = 16'h0000; row = 5'd0; col = 7'd0;
        blank_lz = 1'b0; auto_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ram_we !== 1'b0 ||
            ram_addr !== 12'd0 || ram_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b we=%b addr=%0d data=%h, want all 0",
                     busy, done, ram_we, ram_addr, ram_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [7:0] exp_d [0:3];
        exp_d[0] = 8'h31; exp_d[1] = 8'h41; exp_d[2] = 8'h33; exp_d[3] = 8'h46;
        pulse_and_capture(16'h1A3F, 5'd2, 7'd10, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_busy[k] !== 1'b1 || obs_we[k] !== 1'b1 ||
                obs_addr[k] !== 12'(170 + k) || obs_data[k] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL basic_char%0d: got busy=%b we=%b addr=%0d data=%h, want 1 1 %0d %h",
                         k, obs_busy[k], obs_we[k], obs_addr[k], obs_data[k], 170 + k, exp_d[k]);
            end
        end
        n_checks++;
        if (obs_done[4] !== 1'b1 || obs_busy[4] !== 1'b0 || obs_we[4] !== 1'b0 || obs_done[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got done=%b busy=%b we=%b next_done=%b, want 1 0 0 0",
                     obs_done[4], obs_busy[4], obs_we[4], obs_done[5]);
        end
    endtask

    task automatic test_blank;
        logic [15:0] vals [0:1];
        vals[0] = 16'h00B0;
        vals[1] = 16'h0000;
        for (int t = 0; t < 2; t++) begin
            pulse_and_capture(vals[t], 5'd7, 7'd40, 1'b1);
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (obs_we[k] !== 1'b1 || obs_data[k] !== model_char(vals[t], k, 1'b1)) begin
                    n_fail++;
                    $display("FAIL blank_v%h_char%0d: got we=%b data=%h, want 1 %h",
                             vals[t], k, obs_we[k], obs_data[k], model_char(vals[t], k, 1'b1));
                end
            end
        end
    endtask

    task automatic test_clip;
        int rs [0:1];
        int cs [0:1];
        rs[0] = 4;  cs[0] = 78;
        rs[1] = 31; cs[1] = 5;
        for (int t = 0; t < 2; t++) begin
            pulse_and_capture(16'h1234, 5'(rs[t]), 7'(cs[t]), 1'b0);
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (obs_busy[k] !== 1'b1 || obs_we[k] !== model_we(rs[t], cs[t], k) ||
                    (obs_we[k] === 1'b1 && (obs_addr[k] !== model_addr(rs[t], cs[t], k) ||
                                            obs_data[k] !== model_char(16'h1234, k, 1'b0)))) begin
                    n_fail++;
                    $display("FAIL clip_r%0d_c%0d_k%0d: got busy=%b we=%b addr=%0d data=%h, want 1 %b %0d %h",
                             rs[t], cs[t], k, obs_busy[k], obs_we[k], obs_addr[k], obs_data[k],
                             model_we(rs[t], cs[t], k), model_addr(rs[t], cs[t], k),
                             model_char(16'h1234, k, 1'b0));
                end
            end
            n_checks++;
            if (obs_done[4] !== 1'b1 || obs_we[4] !== 1'b0) begin
                n_fail++;
                $display("FAIL clip_done_r%0d: got done=%b we=%b, want 1 0", rs[t], obs_done[4], obs_we[4]);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] v;
        int r, c;
        logic blz;
        for (int n = 0; n < 30; n++) begin
            v   = 16'($urandom) >> $urandom_range(0, 15);
            r   = $urandom_range(0, 31);
            c   = $urandom_range(0, 99);
            blz = 1'($urandom_range(0, 1));
            pulse_and_capture(v, 5'(r), 7'(c), blz);
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (obs_busy[k] !== 1'b1 || obs_we[k] !== model_we(r, c, k) ||
                    obs_addr[k] !== model_addr(r, c, k) || obs_data[k] !== model_char(v, k, blz)) begin
                    n_fail++;
                    $display("FAIL random%0d_k%0d v=%h r=%0d c=%0d blz=%b: got busy=%b we=%b addr=%0d data=%h, want 1 %b %0d %h",
                             n, k, v, r, c, blz, obs_busy[k], obs_we[k], obs_addr[k], obs_data[k],
                             model_we(r, c, k), model_addr(r, c, k), model_char(v, k, blz));
                end
            end
            n_checks++;
            if (obs_done[4] !== 1'b1 || obs_busy[4] !== 1'b0 || obs_done[5] !== 1'b0) begin
                n_fail++;
                $display("FAIL random%0d_done: got done=%b busy=%b next_done=%b, want 1 0 0",
                         n, obs_done[4], obs_busy[4], obs_done[5]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int   rises [$];
        int   dones;
        logic pb;
        value = 16'h9C0E; row = 5'd1; col = 7'd0; blank_lz = 1'b0; auto_en = 1'b0;
        pb = 1'b0;
        start = 1'b1;
        for (int cyc = 0; cyc <= 24; cyc++) begin
            @(negedge clk);
            if (busy && !pb) rises.push_back(cyc);
            pb = busy;
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (rises.size() != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d sequences, want 4", rises.size());
        end else begin
            for (int k = 1; k < 4; k++) begin
                n_checks++;
                if (rises[k] - rises[k-1] != DIGITS + 2) begin
                    n_fail++;
                    $display("FAIL b2b_period%0d: got %0d cycles, want %0d", k, rises[k] - rises[k-1], DIGITS + 2);
                end
            end
        end

        // A second start pulse while busy must be dropped, not queued.
        rises.delete();
        pb = 1'b0;
        dones = 0;
        start = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            start = (cyc == 2);
            if (busy && !pb) rises.push_back(cyc);
            pb = busy;
            if (done) dones++;
        end
        n_checks++;
        if (rises.size() != 1 || dones != 1) begin
            n_fail++;
            $display("FAIL start_while_busy: got %0d sequences %0d done pulses, want 1 1", rises.size(), dones);
        end
    endtask

    task automatic test_auto;
        logic [7:0] wdata [$];
        int         done_cyc [$];
        int         first_w [$];
        logic       pb;
        logic [15:0] ev;
        reset = 1'b1; auto_en = 1'b1; value = 16'h0005; row = 5'd3; col = 7'd0;
        blank_lz = 1'b0; start = 1'b0;
        pb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (cyc == 3) value = 16'h0006;
            if (ram_we) wdata.push_back(ram_data);
            if (busy && !pb) first_w.push_back(cyc);
            pb = busy;
            if (done) done_cyc.push_back(cyc);
        end
        auto_en = 1'b0;
        n_checks++;
        if (wdata.size() != 8 || done_cyc.size() != 2 || first_w.size() != 2) begin
            n_fail++;
            $display("FAIL auto_counts: got writes=%0d dones=%0d seqs=%0d, want 8 2 2",
                     wdata.size(), done_cyc.size(), first_w.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                ev = (k < 4) ? 16'h0005 : 16'h0006;
                n_checks++;
                if (wdata[k] !== model_char(ev, k % 4, 1'b0)) begin
                    n_fail++;
                    $display("FAIL auto_char%0d: got %h, want %h", k, wdata[k], model_char(ev, k % 4, 1'b0));
                end
            end
            n_checks++;
            if (first_w[0] != 2 || first_w[1] != done_cyc[0] + 2) begin
                n_fail++;
                $display("FAIL auto_timing: got first writes at %0d,%0d done at %0d, want 2,%0d",
                         first_w[0], first_w[1], done_cyc[0], done_cyc[0] + 2);
            end
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        int busies;
        int writes;
        reset = 1'b1; auto_en = 1'b0; start = 1'b0; value = 16'h0000; row = 5'd0;
        col = 7'd20; blank_lz = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: got we=%b busy=%b done=%b, want 0 0 0", ram_we, busy, done);
        end
        reset = 1'b0;
        dones = 0;
        busies = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busies++;
        end
        n_checks++;
        if (dones != 0 || busies != 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got %0d done %0d busy cycles, want 0 0", dones, busies);
        end
        auto_en = 1'b1;
        writes = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (ram_we) writes++;
        end
        auto_en = 1'b0;
        n_checks++;
        if (writes != 4) begin
            n_fail++;
            $display("FAIL reset_mid_auto: got %0d writes, want 4", writes);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_blank();
        test_clip();
        test_random();
        test_back_to_back();
        test_auto();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
